// File: rtl/classify_pkg.sv
// rtl/classify_pkg.sv - shared types and constants for the classification sequencer
package classify_pkg;

  localparam int SCORE_W          = 16;
  localparam int ROW_W            = 4;
  localparam int DEFAULT_NUM_ROWS = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  // Strict greater-than; equal scores never win, so ties keep the earlier row.
  function automatic logic score_gt(input logic [SCORE_W-1:0] a,
                                    input logic [SCORE_W-1:0] b,
                                    input logic               is_signed);
    if (is_signed) return $signed(a) > $signed(b);
    return a > b;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - clearable up-counter with a rollover flag
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] w_next;

  assign w_next = count_out + 1'b1;

  // Flag marks the edge on which the count reaches rollover_val; the count wraps to zero there.
  assign rollover_flag = count_enable && !clear && (w_next == rollover_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      count_out <= rollover_flag ? '0 : w_next;
    end
  end

endmodule

// File: rtl/classify_controller.sv
// rtl/classify_controller.sv - issues one multiplier job per class and tracks the arg-max score
module classify_controller
  import classify_pkg::*;
#(
  parameter int NUM_ROWS       = DEFAULT_NUM_ROWS,
  parameter int TIMEOUT        = 1023,
  parameter int SIGNED_COMPARE = 1
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               done_row,
  input  logic [SCORE_W-1:0] row_result,
  output logic               begin_mult,
  output logic [ROW_W-1:0]   row_select,
  output logic               busy,
  output logic               class_valid,
  output logic [ROW_W-1:0]   class_index,
  output logic [SCORE_W-1:0] class_score,
  output logic               error,
  input  logic [ROW_W-1:0]   score_rd_addr,
  output logic [SCORE_W-1:0] score_rd_data
);

  state_t             r_state;
  state_t             w_next_state;
  logic [SCORE_W-1:0] r_score [2**ROW_W];
  logic [SCORE_W-1:0] r_max_score;
  logic [ROW_W-1:0]   r_max_idx;
  logic               w_rollover;
  logic               w_done;
  logic               w_timeout;
  logic               w_last;
  logic [9:0]         w_unused_count;

  flex_counter #(.NUM_CNT_BITS(10)) u_timeout (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (r_state == ISSUE),
    .count_enable (r_state == WAIT),
    .rollover_val (10'(TIMEOUT)),
    .count_out    (w_unused_count),
    .rollover_flag(w_rollover)
  );

  // A row completion in the same cycle as the timeout takes priority.
  assign w_done    = (r_state == WAIT) && done_row;
  assign w_timeout = (r_state == WAIT) && !done_row && w_rollover;
  assign w_last    = (row_select == ROW_W'(NUM_ROWS - 1));

  assign begin_mult    = (r_state == ISSUE);
  assign busy          = (r_state == ISSUE) || (r_state == WAIT);
  assign score_rd_data = (int'(score_rd_addr) < NUM_ROWS) ? r_score[score_rd_addr] : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = ISSUE;
      ISSUE:   w_next_state = WAIT;
      WAIT: begin
        if (w_done)         w_next_state = w_last ? FINISH : ISSUE;
        else if (w_timeout) w_next_state = IDLE;
      end
      FINISH:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row_select  <= '0;
      class_valid <= 1'b0;
      class_index <= '0;
      class_score <= '0;
      error       <= 1'b0;
      r_max_score <= '0;
      r_max_idx   <= '0;
      for (int i = 0; i < 2**ROW_W; i++) r_score[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            row_select  <= '0;
            class_valid <= 1'b0;
            error       <= 1'b0;
          end
        end
        WAIT: begin
          if (w_done) begin
            r_score[row_select] <= row_result;
            if ((row_select == '0) ||
                score_gt(row_result, r_max_score, SIGNED_COMPARE != 0)) begin
              r_max_score <= row_result;
              r_max_idx   <= row_select;
            end
            if (!w_last) row_select <= row_select + 1'b1;
          end else if (w_timeout) begin
            error <= 1'b1;
          end
        end
        FINISH: begin
          class_index <= r_max_idx;
          class_score <= r_max_score;
          class_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_classify_controller.sv
// tb/tb_classify_controller.sv - directed self-checking bench for classify_controller
module tb_classify_controller;
  import classify_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        extra_done = 1'b0;
  logic        done_row;
  logic [15:0] row_result;
  logic [3:0]  score_rd_addr = 4'd0;

  logic        begin_mult, busy, class_valid, error;
  logic [3:0]  row_select, class_index;
  logic [15:0] class_score, score_rd_data;
  logic        begin_mult_u, busy_u, class_valid_u, error_u;
  logic [3:0]  row_select_u, class_index_u;
  logic [15:0] class_score_u, score_rd_data_u;

  int n_cmp = 0;
  int n_err = 0;

  // Mock multiplier: done_row arrives mock_lat cycles after the cycle begin_mult is seen.
  logic        mock_done = 1'b0;
  logic [15:0] mock_data = 16'd0;
  logic [15:0] mock_scores [16];
  int          mock_lat = 3;
  int          mock_hold = -1;
  logic        mock_clr = 1'b0;
  bit          mock_pending = 1'b0;
  int          mock_cnt = 0;
  int          mock_row = 0;
  int          n_begin = 0;
  int          begin_rows [32];

  assign done_row   = mock_done | extra_done;
  assign row_result = mock_data;

  always #5 clk = ~clk;

  classify_controller #(.SIGNED_COMPARE(1)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .done_row(done_row), .row_result(row_result),
    .begin_mult(begin_mult), .row_select(row_select), .busy(busy), .class_valid(class_valid),
    .class_index(class_index), .class_score(class_score), .error(error),
    .score_rd_addr(score_rd_addr), .score_rd_data(score_rd_data)
  );

  classify_controller #(.SIGNED_COMPARE(0)) dut_u (
    .clk(clk), .n_rst(n_rst), .start(start), .done_row(done_row), .row_result(row_result),
    .begin_mult(begin_mult_u), .row_select(row_select_u), .busy(busy_u), .class_valid(class_valid_u),
    .class_index(class_index_u), .class_score(class_score_u), .error(error_u),
    .score_rd_addr(score_rd_addr), .score_rd_data(score_rd_data_u)
  );

  always @(posedge clk) begin
    #1;
    mock_done = 1'b0;
    if (!n_rst || mock_clr) begin
      mock_pending = 1'b0;
      n_begin      = 0;
    end else if (mock_pending) begin
      mock_cnt++;
      if (mock_cnt == mock_lat) begin
        mock_pending = 1'b0;
        if (mock_row != mock_hold) begin
          mock_done = 1'b1;
          mock_data = mock_scores[mock_row];
        end
      end
    end else if (begin_mult) begin
      mock_pending = 1'b1;
      mock_cnt     = 0;
      mock_row     = int'(row_select);
      if (n_begin < 32) begin_rows[n_begin] = mock_row;
      n_begin++;
    end
  end

  task automatic load_basic_scores();
    for (int r = 0; r < 16; r++) mock_scores[r] = 16'(100 + 10 * r);
    mock_scores[7] = 16'd5000;
  endtask

  // Pulses start and returns cycles from the start cycle until class_valid (-1 if never).
  task automatic run_class(input int poke_row, output int cycles);
    bit poked;
    poked = 1'b0;
    @(negedge clk); mock_clr = 1'b1;
    @(negedge clk); mock_clr = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; cycles = 1;
    while (!class_valid && !error && cycles < 8000) begin
      start = 1'b0;
      if (poke_row >= 0 && !poked && busy && !begin_mult && int'(row_select) == poke_row) begin
        start = 1'b1;
        poked = 1'b1;
      end
      @(negedge clk); cycles++;
    end
    start = 1'b0;
    if (!class_valid) cycles = -1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (begin_mult !== 1'b0) begin n_err++; $display("FAIL rst_begin_mult: got %b expected 0", begin_mult); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if ({class_valid, error} !== 2'b00) begin n_err++; $display("FAIL rst_valid_error: got %b expected 00", {class_valid, error}); end
    n_cmp++; if ({row_select, class_index, class_score} !== 24'd0) begin n_err++; $display("FAIL rst_indices: got %h expected 0", {row_select, class_index, class_score}); end
    n_cmp++; if (score_rd_data !== 16'd0) begin n_err++; $display("FAIL rst_score0: got %0d expected 0", score_rd_data); end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int  c;
    bit  seq_ok;
    load_basic_scores();
    mock_lat = 395;
    run_class(-1, c);
    n_cmp++; if (c != 1 + 10 * 396 + 1) begin n_err++; $display("FAIL basic_latency: got %0d expected %0d", c, 1 + 10 * 396 + 1); end
    n_cmp++; if (class_index !== 4'd7) begin n_err++; $display("FAIL basic_index: got %0d expected 7", class_index); end
    n_cmp++; if (class_score !== 16'd5000) begin n_err++; $display("FAIL basic_score: got %0d expected 5000", class_score); end
    n_cmp++; if (n_begin != 10) begin n_err++; $display("FAIL basic_begin_count: got %0d expected 10", n_begin); end
    seq_ok = 1'b1;
    for (int i = 0; i < 10; i++) if (begin_rows[i] != i) seq_ok = 1'b0;
    n_cmp++; if (!seq_ok) begin n_err++; $display("FAIL basic_row_sequence: got rows out of order expected 0..9"); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_readback();
    score_rd_addr = 4'd7; #1;
    n_cmp++; if (score_rd_data !== 16'd5000) begin n_err++; $display("FAIL rd_addr7: got %0d expected 5000", score_rd_data); end
    score_rd_addr = 4'd9; #1;
    n_cmp++; if (score_rd_data !== 16'd190) begin n_err++; $display("FAIL rd_addr9: got %0d expected 190", score_rd_data); end
    score_rd_addr = 4'd12; #1;
    n_cmp++; if (score_rd_data !== 16'd0) begin n_err++; $display("FAIL rd_addr12: got %0d expected 0", score_rd_data); end
    score_rd_addr = 4'd0;
  endtask

  task automatic test_tie();
    int c;
    for (int r = 0; r < 16; r++) mock_scores[r] = 16'h0001;
    mock_scores[2] = 16'h7FFF;
    mock_scores[5] = 16'h7FFF;
    mock_lat = 2;
    run_class(-1, c);
    n_cmp++; if (c != 32) begin n_err++; $display("FAIL tie_latency: got %0d expected 32", c); end
    n_cmp++; if (class_index !== 4'd2) begin n_err++; $display("FAIL tie_index: got %0d expected 2", class_index); end
    n_cmp++; if (class_score !== 16'h7FFF) begin n_err++; $display("FAIL tie_score: got %h expected 7fff", class_score); end
  endtask

  task automatic test_sign_mode();
    int c;
    for (int r = 0; r < 16; r++) mock_scores[r] = 16'h0000;
    mock_scores[3] = 16'hFFFF;
    mock_scores[6] = 16'h0010;
    mock_lat = 1;
    run_class(-1, c);
    n_cmp++; if (class_index !== 4'd6) begin n_err++; $display("FAIL sign_signed_index: got %0d expected 6", class_index); end
    n_cmp++; if (class_score !== 16'h0010) begin n_err++; $display("FAIL sign_signed_score: got %h expected 0010", class_score); end
    n_cmp++; if (class_index_u !== 4'd3) begin n_err++; $display("FAIL sign_unsigned_index: got %0d expected 3", class_index_u); end
    n_cmp++; if (class_score_u !== 16'hFFFF) begin n_err++; $display("FAIL sign_unsigned_score: got %h expected ffff", class_score_u); end
  endtask

  task automatic test_timeout();
    int k;
    int c;
    mock_lat  = 3;
    mock_hold = 2;
    @(negedge clk); mock_clr = 1'b1;
    @(negedge clk); mock_clr = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(begin_mult && row_select == 4'd2) && k < 200) begin @(negedge clk); k++; end
    n_cmp++; if (k >= 200) begin n_err++; $display("FAIL timeout_reach_row2: got no begin_mult for row 2 expected one"); end
    // error rises TIMEOUT edges after the edge that samples row 2's begin_mult
    repeat (1023) @(negedge clk);
    n_cmp++; if ({error, busy} !== 2'b01) begin n_err++; $display("FAIL timeout_early: got error,busy=%b expected 01", {error, busy}); end
    @(negedge clk);
    n_cmp++; if (error !== 1'b1) begin n_err++; $display("FAIL timeout_error: got %b expected 1", error); end
    n_cmp++; if ({busy, class_valid} !== 2'b00) begin n_err++; $display("FAIL timeout_busy_valid: got %b expected 00", {busy, class_valid}); end
    n_cmp++; if (row_select !== 4'd2) begin n_err++; $display("FAIL timeout_row_select: got %0d expected 2", row_select); end
    mock_hold = -1;
    run_class(-1, c);
    n_cmp++; if (error !== 1'b0) begin n_err++; $display("FAIL timeout_recover_error: got %b expected 0", error); end
    n_cmp++; if (c != 42 || class_index !== 4'd6) begin n_err++; $display("FAIL timeout_recover_run: got cycles %0d index %0d expected 42 and 6", c, class_index); end
  endtask

  task automatic test_ignored_inputs();
    int c;
    load_basic_scores();
    mock_lat = 3;
    run_class(4, c);
    n_cmp++; if (c != 42) begin n_err++; $display("FAIL ignore_latency: got %0d expected 42", c); end
    n_cmp++; if (n_begin != 10) begin n_err++; $display("FAIL ignore_begin_count: got %0d expected 10", n_begin); end
    @(negedge clk); extra_done = 1'b1;
    @(negedge clk); extra_done = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (class_index !== 4'd7 || class_score !== 16'd5000) begin n_err++; $display("FAIL ignore_result: got %0d/%0d expected 7/5000", class_index, class_score); end
    n_cmp++; if ({class_valid, busy, begin_mult} !== 3'b100) begin n_err++; $display("FAIL ignore_idle_state: got %b expected 100", {class_valid, busy, begin_mult}); end
    score_rd_addr = 4'd3; #1;
    n_cmp++; if (score_rd_data !== 16'd130) begin n_err++; $display("FAIL ignore_score3: got %0d expected 130", score_rd_data); end
    score_rd_addr = 4'd0;
  endtask

  task automatic test_reset_mid_run();
    int k;
    int c;
    load_basic_scores();
    mock_lat = 3;
    @(negedge clk); mock_clr = 1'b1;
    @(negedge clk); mock_clr = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(busy && !begin_mult && row_select == 4'd5) && k < 200) begin @(negedge clk); k++; end
    n_cmp++; if (k >= 200) begin n_err++; $display("FAIL midrst_reach_row5: got no WAIT on row 5 expected one"); end
    n_rst = 1'b0; #1;
    n_cmp++; if ({begin_mult, busy, class_valid, error} !== 4'b0000) begin n_err++; $display("FAIL midrst_flags: got %b expected 0000", {begin_mult, busy, class_valid, error}); end
    n_cmp++; if ({row_select, class_index, class_score} !== 24'd0) begin n_err++; $display("FAIL midrst_indices: got %h expected 0", {row_select, class_index, class_score}); end
    score_rd_addr = 4'd4; #1;
    n_cmp++; if (score_rd_data !== 16'd0) begin n_err++; $display("FAIL midrst_score4: got %0d expected 0", score_rd_data); end
    score_rd_addr = 4'd0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({begin_mult, busy} !== 2'b00) begin n_err++; $display("FAIL midrst_no_issue: got %b expected 00", {begin_mult, busy}); end
    run_class(-1, c);
    n_cmp++; if (n_begin < 1 || begin_rows[0] != 0) begin n_err++; $display("FAIL midrst_first_row: got %0d expected 0", (n_begin < 1) ? -1 : begin_rows[0]); end
    n_cmp++; if (c != 42 || class_index !== 4'd7) begin n_err++; $display("FAIL midrst_rerun: got cycles %0d index %0d expected 42 and 7", c, class_index); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_readback();
    test_tie();
    test_sign_mode();
    test_timeout();
    test_ignored_inputs();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
